// File: rtl/test_value_uart_tx.sv
// Watches the processor's 16-bit test_value and ships each new value (or a requested resend)
// as an 8N1 UART frame: HEADER, value[15:8], value[7:0]. Newest-wins single-entry buffering.
module test_value_uart_tx #(
  parameter int          VALUE_WIDTH  = 16,
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [VALUE_WIDTH-1:0] test_value,
  input  logic                   send_req,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done,
  output logic [1:0]             dbg_state
);

  localparam int               BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int               FRAME_W   = VALUE_WIDTH + 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]             r_state;
  logic [VALUE_WIDTH-1:0] r_last_value;
  logic [VALUE_WIDTH-1:0] r_snapshot;
  logic                   r_pending;
  logic [FRAME_W-1:0]     r_frame;
  logic [BAUD_W-1:0]      r_baud;
  logic [2:0]             r_bit_idx;
  logic [1:0]             r_byte_idx;
  logic                   r_tx;
  logic                   r_frame_done;

  logic                   w_change;
  logic                   w_take;
  logic                   w_baud_done;
  logic [2:0]             w_next_bit_idx;
  logic [7:0]             w_cur_byte;

  assign w_change       = (test_value != r_last_value) || send_req;
  assign w_take         = (r_state == S_IDLE) && r_pending;
  assign w_baud_done    = (r_baud == BAUD_LAST);
  assign w_next_bit_idx = r_bit_idx + 3'd1;

  always_comb begin
    w_cur_byte = r_frame[7:0];
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_frame[23:16];
      2'd1:    w_cur_byte = r_frame[15:8];
      default: w_cur_byte = r_frame[7:0];
    endcase
  end

  // A change seen in the same cycle the FSM consumes pending keeps it set, so nothing is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_value <= '0;
      r_snapshot   <= '0;
      r_pending    <= 1'b0;
    end else begin
      r_last_value <= test_value;
      if (w_change) begin
        r_snapshot <= test_value;
        r_pending  <= 1'b1;
      end else if (w_take) begin
        r_pending  <= 1'b0;
      end
    end
  end

  // tx is registered and updated on the same edge as each state/bit transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_frame      <= '0;
      r_baud       <= '0;
      r_bit_idx    <= '0;
      r_byte_idx   <= '0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_take) begin
            r_frame    <= {HEADER, r_snapshot};
            r_byte_idx <= '0;
            r_baud     <= '0;
            r_tx       <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= w_cur_byte[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= w_next_bit_idx;
              r_tx      <= w_cur_byte[w_next_bit_idx];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_byte_idx < 2'd2) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_frame_done <= 1'b1;
              r_state      <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_test_value_uart_tx.sv
// Bench for test_value_uart_tx with CLKS_PER_BIT=4 (120 cycles per frame): table of single
// transactions plus hand-written overwrite, reset-abort and frame_done-collision sequences.
module tb_test_value_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] value;
    logic        send;
    logic [23:0] frame;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] test_value;
  logic        send_req;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  test_value_uart_tx #(
    .VALUE_WIDTH (16),
    .CLKS_PER_BIT(CPB),
    .HEADER      (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .test_value(test_value),
    .send_req  (send_req),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Changes inputs after edge k, clears send_req after edge k+1.
  task automatic apply_vec(input logic [15:0] value, input logic send);
    @(posedge clk); #1;
    test_value = value;
    send_req   = send;
    @(posedge clk); #1;
    send_req   = 1'b0;
  endtask

  // Counts negedges until tx is seen low; returns with that start-bit sample current.
  task automatic wait_tx_fall(input string name, input int exp_lat);
    int lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        lat = i;
        break;
      end
    end
    check({name, " start latency"}, lat, exp_lat);
  endtask

  // Samples 120 cycles of tx, decodes three 8N1 bytes, then checks the frame_done cycle.
  task automatic capture_and_check(input string name, input logic [23:0] exp);
    logic [119:0] s;
    logic [7:0]   got [3];
    logic         lvl;
    int           busy_n = 0;
    int           fd_n = 0;
    int           shape_bad = 0;
    int           g;
    s[0] = tx;
    busy_n += int'(busy);
    fd_n   += int'(frame_done);
    for (int i = 1; i < 120; i++) begin
      @(negedge clk);
      s[i] = tx;
      busy_n += int'(busy);
      fd_n   += int'(frame_done);
    end
    for (int b = 0; b < 3; b++) begin
      got[b] = 8'h00;
      for (int j = 0; j < 10; j++) begin
        g   = b * 10 + j;
        lvl = s[g*CPB + 2];
        for (int t = 0; t < CPB; t++)
          if (s[g*CPB + t] !== lvl) shape_bad++;
        if (j == 0 && lvl !== 1'b0) shape_bad++;
        if (j == 9 && lvl !== 1'b1) shape_bad++;
        if (j >= 1 && j <= 8) got[b][j-1] = lvl;
      end
    end
    check({name, " byte0"}, {24'h0, got[0]}, {24'h0, exp[23:16]});
    check({name, " byte1"}, {24'h0, got[1]}, {24'h0, exp[15:8]});
    check({name, " byte2"}, {24'h0, got[2]}, {24'h0, exp[7:0]});
    check({name, " bit shape errors"}, shape_bad, 0);
    check({name, " busy cycles"}, busy_n, 120);
    check({name, " early frame_done"}, fd_n, 0);
    @(negedge clk);
    check({name, " frame_done pulse"}, {31'h0, frame_done}, 32'h1);
    check({name, " busy in done cycle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic expect_quiet(input string name, input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check({name, " quiet"}, bad, 0);
  endtask

  initial begin
    vec_t vecs [5];
    vecs[0] = '{value: 16'h9ABC, send: 1'b1, frame: 24'hA59ABC};
    vecs[1] = '{value: 16'h0000, send: 1'b0, frame: 24'hA50000};
    vecs[2] = '{value: 16'hFFFF, send: 1'b0, frame: 24'hA5FFFF};
    vecs[3] = '{value: 16'h8001, send: 1'b1, frame: 24'hA58001};
    vecs[4] = '{value: 16'h5AC3, send: 1'b0, frame: 24'hA55AC3};

    reset      = 1'b1;
    test_value = 16'h0000;
    send_req   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx", {31'h0, tx}, 32'h1);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset frame_done", {31'h0, frame_done}, 32'h0);
    check("reset state", {30'h0, dbg_state}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    expect_quiet("idle after reset", 300);

    // First frame, with two overwrites while it is in flight; only the newest follows.
    fork
      begin
        apply_vec(16'h1234, 1'b0);
        wait_tx_fall("frame 1234", 2);
        capture_and_check("frame 1234", 24'hA51234);
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(posedge clk);
          if (busy === 1'b1) break;
        end
        repeat (30) @(posedge clk);
        #1 test_value = 16'h5678;
        repeat (30) @(posedge clk);
        #1 test_value = 16'h9ABC;
      end
    join
    wait_tx_fall("newest 9ABC", 1);
    capture_and_check("newest 9ABC", 24'hA59ABC);
    expect_quiet("after overwrite", 60);

    for (int v = 0; v < 5; v++) begin
      apply_vec(vecs[v].value, vecs[v].send);
      wait_tx_fall($sformatf("vec%0d", v), 2);
      capture_and_check($sformatf("vec%0d", v), vecs[v].frame);
      expect_quiet($sformatf("vec%0d", v), 20);
    end

    // Abort a frame with reset during its 16th bit (index 15).
    apply_vec(16'h4321, 1'b0);
    wait_tx_fall("abort 4321", 2);
    repeat (61) @(posedge clk);
    #1;
    reset      = 1'b1;
    test_value = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    check("abort tx", {31'h0, tx}, 32'h1);
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort frame_done", {31'h0, frame_done}, 32'h0);
    expect_quiet("held reset", 3);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    wait_tx_fall("post reset 0001", 2);
    capture_and_check("post reset 0001", 24'hA50001);

    // Now in the frame_done cycle: change the value right here.
    test_value = 16'h00FF;
    wait_tx_fall("collide 00FF", 2);
    capture_and_check("collide 00FF", 24'hA500FF);
    expect_quiet("final", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/test_value_uart_tx.md
Name: test_value_uart_tx

Overview:
- Downstream consumer of the processor's 16-bit test_value observation output.
- Watches test_value and, whenever it changes or a send is requested, serialises a 3-byte frame over a UART 8N1 line to the bench/host: header 0xA5, then the high byte, then the low byte.
- Single-entry, newest-wins buffering decouples the processor rate from the UART rate.

Parameters:
- VALUE_WIDTH, 16, width of test_value; fixed at 16 for the 2-data-byte frame format.
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Legal range is >= 2.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- test_value  input  16  value to monitor, sampled every cycle.
- send_req  input  1  one-cycle request to send the current test_value even if unchanged.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a frame is being shifted out.
- frame_done  output  1  one-cycle pulse when the last stop bit of a frame ends.

Behaviour:
- Reset (sync, active-high): tx=1, busy=0, frame_done=0, state=IDLE, last_value=0, pending=0, snapshot=0, bit/byte/baud counters=0.
  - Reset asserted mid-frame aborts the frame: tx=1 and busy=0 from the edge where reset is sampled.
- Change detect:
  - Every cycle, last_value <= test_value.
  - If test_value != last_value or send_req=1: snapshot <= test_value and pending <= 1.
  - This applies during busy too. A later change overwrites snapshot (newest wins; intermediate values are dropped).
- Post-reset send: because last_value resets to 0, a nonzero test_value after reset produces one frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If pending: frame_reg <= {HEADER, snapshot}, pending <= 0, byte_idx <= 0, go to START.
    - pending may be set and consumed in back-to-back cycles. The latest snapshot wins if set the same cycle as consumption.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Byte order: HEADER, snapshot[15:8], snapshot[7:0]. Then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx < 2: byte_idx++, go to START (no inter-byte gap).
    - Otherwise: assert frame_done for 1 cycle and go to IDLE. busy is 0 in that same cycle.
- busy is 1 in START, DATA and STOP.
- Latency: test_value changes at edge k → pending=1 after edge k+1 → START entered at edge k+2. tx falls at k+2 when the FSM is idle.
- Frame length: exactly 30*CLKS_PER_BIT cycles from tx falling to frame_done.
- Back-to-back frames: minimum one IDLE cycle between frame_done and the next start bit.
- frame_reg is stable for the whole frame; input changes mid-frame never corrupt the bits in flight.
- Simultaneous events:
  - A change in the same cycle as frame_done is captured into pending, and the next frame follows after one IDLE cycle.
  - send_req together with a change behaves as a single request.

Test Plan (CLKS_PER_BIT=4, so 120 cycles per frame):
- Reset with test_value=0 held for 300 cycles → tx=1, busy=0, frame_done never pulses.
- test_value 0→0x1234 at edge k → tx low at k+2; decoded bytes A5, 12, 34; each bit 4 cycles; frame_done pulse at k+122; busy high for exactly 120 cycles.
- During the 0x1234 frame, change to 0x5678, then 0x9ABC → first frame unaffected; exactly one following frame A5, 9A, BC, starting one IDLE cycle after frame_done.
- test_value held at 0x9ABC, single-cycle send_req → one frame A5, 9A, BC; no further frames.
- Assert reset during bit 15 of a frame → tx=1 and busy=0 from the next edge, no frame_done. Release reset with test_value=0x0001 → one frame A5, 00, 01.
- Change test_value to 0x00FF in the exact frame_done cycle → a second frame A5, 00, FF starts one cycle later; no frame is lost.
